// File: rtl/regfile_bist_if.sv
// Port bundle between the register-file BIST controller and its surroundings
// (start/status handshake plus the register file's write and read ports).
interface regfile_bist_if;
    logic        Start;
    logic        Busy;
    logic        Done;
    logic        Pass;
    logic [5:0]  FailCount;
    logic [4:0]  FailAddr;
    logic [1:0]  FailPhase;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteData;
    logic [4:0]  WriteRegister;
    logic        RegWrite;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;

    modport master (
        input  Start, ReadData1, ReadData2,
        output Busy, Done, Pass, FailCount, FailAddr, FailPhase,
        output WriteData, WriteRegister, RegWrite, ReadRegister1, ReadRegister2
    );

    modport slave (
        output Start, ReadData1, ReadData2,
        input  Busy, Done, Pass, FailCount, FailAddr, FailPhase,
        input  WriteData, WriteRegister, RegWrite, ReadRegister1, ReadRegister2
    );
endinterface

// File: rtl/regfile_bist.sv
// Three-phase pattern BIST for a 32x32 register file with r0 hardwired to zero:
// write pattern, write inverted pattern, then a write-disabled pass that must not disturb data.
module regfile_bist #(
    parameter logic [31:0] PATTERN      = 32'hA5A55A5A,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input logic            Clk,
    input logic            Reset,
    regfile_bist_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [5:0]  fail_count_q, fail_count_d;
    logic [4:0]  fail_addr_q, fail_addr_d;
    logic [1:0]  fail_phase_q, fail_phase_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  wreg_q, wreg_d, rd1_q, rd1_d, rd2_q, rd2_d;
    logic        regwrite_q, regwrite_d;
    logic        mis1, mis2;
    logic [6:0]  sum;

    function automatic logic [31:0] exp_val(input logic [1:0] p, input logic [4:0] r);
        logic [31:0] base;
        base = PATTERN ^ {27'd0, r};
        if (r == 5'd0)      return 32'd0;
        else if (p == 2'd0) return base;
        else                return ~base;
    endfunction

    // Compare against the addresses driven this cycle (the registered read-port outputs).
    assign mis1 = (state_q == S_RD) && (bus.ReadData1 != exp_val(phase_q, rd1_q));
    assign mis2 = (state_q == S_RD) && (bus.ReadData2 != exp_val(phase_q, rd2_q));
    assign sum  = {1'b0, fail_count_q} + 7'(mis1) + 7'(mis2);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        fail_count_d = fail_count_q;
        fail_addr_d  = fail_addr_q;
        fail_phase_d = fail_phase_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    state_d      = S_WR;
                    cnt_d        = 5'd0;
                    phase_d      = 2'd0;
                    fail_count_d = 6'd0;
                    fail_addr_d  = 5'd0;
                    fail_phase_d = 2'd0;
                end
            end
            S_WR: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_RD;
                    cnt_d   = 5'd0;
                end
            end
            S_RD: begin
                fail_count_d = (sum > 7'd63) ? 6'd63 : sum[5:0];
                if (fail_count_q == 6'd0 && (mis1 || mis2)) begin
                    fail_addr_d  = mis1 ? rd1_q : rd2_q;
                    fail_phase_d = phase_q;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    cnt_d = 5'd0;
                    if (phase_q == 2'd2) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WR;
                        phase_d = phase_q + 2'd1;
                    end
                end
                if (STOP_ON_FAIL && (mis1 || mis2)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port outputs are derived from the next state so they are registered yet aligned with it.
    always_comb begin
        busy_d     = (state_d == S_WR) || (state_d == S_RD);
        done_d     = (state_d == S_DONE);
        pass_d     = done_d && (fail_count_d == 6'd0);
        wdata_d    = 32'd0;
        wreg_d     = 5'd0;
        regwrite_d = 1'b0;
        rd1_d      = 5'd0;
        rd2_d      = 5'd0;
        if (state_d == S_WR) begin
            wreg_d     = cnt_d;
            wdata_d    = (phase_d == 2'd1) ? ~(PATTERN ^ {27'd0, cnt_d}) : (PATTERN ^ {27'd0, cnt_d});
            regwrite_d = (phase_d != 2'd2);
        end
        if (state_d == S_RD) begin
            rd1_d = {cnt_d[3:0], 1'b0};
            rd2_d = {cnt_d[3:0], 1'b1};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 5'd0;
            phase_q      <= 2'd0;
            fail_count_q <= 6'd0;
            fail_addr_q  <= 5'd0;
            fail_phase_q <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            wdata_q      <= 32'd0;
            wreg_q       <= 5'd0;
            regwrite_q   <= 1'b0;
            rd1_q        <= 5'd0;
            rd2_q        <= 5'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            fail_count_q <= fail_count_d;
            fail_addr_q  <= fail_addr_d;
            fail_phase_q <= fail_phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            wdata_q      <= wdata_d;
            wreg_q       <= wreg_d;
            regwrite_q   <= regwrite_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
        end
    end

    assign bus.Busy          = busy_q;
    assign bus.Done          = done_q;
    assign bus.Pass          = pass_q;
    assign bus.FailCount     = fail_count_q;
    assign bus.FailAddr      = fail_addr_q;
    assign bus.FailPhase     = fail_phase_q;
    assign bus.WriteData     = wdata_q;
    assign bus.WriteRegister = wreg_q;
    assign bus.RegWrite      = regwrite_q;
    assign bus.ReadRegister1 = rd1_q;
    assign bus.ReadRegister2 = rd2_q;
endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: two controllers (run-to-end and stop-on-fail) each driving a
// register-file model with injectable faults, checked against a phase-level reference model.
module tb_regfile_bist;
    localparam logic [31:0] PAT = 32'hA5A55A5A;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    // 0 healthy, 1 reg0 writable, 2 RegWrite ignored, 3 write to dec_src also hits dec_dst
    int   fault = 0;
    int   dec_src = 17;
    int   dec_dst = 16;
    logic [31:0] rf0 [32];
    logic [31:0] rf1 [32];

    always #5 Clk = ~Clk;

    regfile_bist_if b0();
    regfile_bist_if b1();

    regfile_bist #(.PATTERN(PAT), .STOP_ON_FAIL(1'b0)) dut   (.Clk(Clk), .Reset(Reset), .bus(b0));
    regfile_bist #(.PATTERN(PAT), .STOP_ON_FAIL(1'b1)) dut_s (.Clk(Clk), .Reset(Reset), .bus(b1));

    always @(posedge Clk) begin
        if (b0.RegWrite || fault == 2) begin
            if (b0.WriteRegister != 5'd0 || fault == 1) rf0[b0.WriteRegister] <= b0.WriteData;
            if (fault == 3 && int'(b0.WriteRegister) == dec_src && dec_dst != 0) rf0[dec_dst] <= b0.WriteData;
        end
        if (b1.RegWrite || fault == 2) begin
            if (b1.WriteRegister != 5'd0 || fault == 1) rf1[b1.WriteRegister] <= b1.WriteData;
            if (fault == 3 && int'(b1.WriteRegister) == dec_src && dec_dst != 0) rf1[dec_dst] <= b1.WriteData;
        end
    end

    assign b0.ReadData1 = (b0.ReadRegister1 == 5'd0 && fault != 1) ? 32'd0 : rf0[b0.ReadRegister1];
    assign b0.ReadData2 = (b0.ReadRegister2 == 5'd0 && fault != 1) ? 32'd0 : rf0[b0.ReadRegister2];
    assign b1.ReadData1 = (b1.ReadRegister1 == 5'd0 && fault != 1) ? 32'd0 : rf1[b1.ReadRegister1];
    assign b1.ReadData2 = (b1.ReadRegister2 == 5'd0 && fault != 1) ? 32'd0 : rf1[b1.ReadRegister2];

    // Whole-test reference: write every register per phase, read every pair, tally mismatches.
    task automatic model(input int fm, input bit stop, output int ecnt, output int eaddr,
                         output int ephase, output int ebusy);
        logic [31:0] m [32];
        logic [31:0] d, got, ex;
        int a;
        bit hit;
        ecnt = 0; eaddr = 0; ephase = 0; ebusy = 144;
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < 32; r++) begin
                d = (p == 1) ? ~(PAT ^ 32'(r)) : (PAT ^ 32'(r));
                if (p != 2 || fm == 2) begin
                    if (r != 0 || fm == 1) m[r] = d;
                    if (fm == 3 && r == dec_src && dec_dst != 0) m[dec_dst] = d;
                end
            end
            for (int k = 0; k < 16; k++) begin
                hit = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    a   = 2 * k + j;
                    got = (a == 0 && fm != 1) ? 32'd0 : m[a];
                    ex  = (a == 0) ? 32'd0 : ((p == 0) ? (PAT ^ 32'(a)) : ~(PAT ^ 32'(a)));
                    if (got !== ex) begin
                        if (ecnt == 0) begin eaddr = a; ephase = p; end
                        if (ecnt < 63) ecnt++;
                        hit = 1'b1;
                    end
                end
                if (stop && hit) begin ebusy = p * 48 + 32 + k + 1; return; end
            end
        end
    endtask

    // Pulse Start on one controller and count Busy cycles (bounded); optional Start noise while busy.
    task automatic run(input bit s, input bit extra, output int busy_n, output int we_n,
                       output logic [31:0] r5, output logic done_after_start);
        @(negedge Clk);
        if (s) b1.Start = 1'b1; else b0.Start = 1'b1;
        @(negedge Clk);
        b0.Start = 1'b0; b1.Start = 1'b0;
        done_after_start = s ? b1.Done : b0.Done;
        busy_n = 0; we_n = 0; r5 = 32'd0;
        for (int i = 0; i < 400; i++) begin
            b0.Start = 1'b0; b1.Start = 1'b0;
            if (!(s ? b1.Busy : b0.Busy)) break;
            busy_n++;
            if (s ? b1.RegWrite : b0.RegWrite) we_n++;
            if (busy_n == 96) r5 = s ? rf1[5] : rf0[5];
            if (extra && $urandom_range(0, 3) == 0) begin
                if (s) b1.Start = 1'b1; else b0.Start = 1'b1;
            end
            @(negedge Clk);
        end
        b0.Start = 1'b0; b1.Start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total += 8;
        if (b0.Busy !== 1'b0 || b1.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b/%b want 0", b0.Busy, b1.Busy); end
        if (b0.Done !== 1'b0 || b0.Pass !== 1'b0) begin bad++; $display("FAIL reset_done_pass got %b%b want 00", b0.Done, b0.Pass); end
        if (b0.FailCount !== 6'd0) begin bad++; $display("FAIL reset_failcount got %0d want 0", b0.FailCount); end
        if (b0.FailAddr !== 5'd0 || b0.FailPhase !== 2'd0) begin bad++; $display("FAIL reset_failinfo got %0d/%0d want 0/0", b0.FailAddr, b0.FailPhase); end
        if (b0.WriteData !== 32'd0) begin bad++; $display("FAIL reset_wdata got %h want 0", b0.WriteData); end
        if (b0.WriteRegister !== 5'd0) begin bad++; $display("FAIL reset_wreg got %0d want 0", b0.WriteRegister); end
        if (b0.RegWrite !== 1'b0 || b1.RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got %b/%b want 0", b0.RegWrite, b1.RegWrite); end
        if (b0.ReadRegister1 !== 5'd0 || b0.ReadRegister2 !== 5'd0) begin bad++; $display("FAIL reset_rdreg got %0d/%0d want 0/0", b0.ReadRegister1, b0.ReadRegister2); end
        @(negedge Clk);
        Reset = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge Clk);
    endtask

    task automatic test_healthy();
        int bn, wn;
        logic [31:0] r5;
        logic d0;
        fault = 0;
        run(1'b0, 1'b1, bn, wn, r5, d0);
        total += 6;
        if (bn !== 144) begin bad++; $display("FAIL healthy_busy_cycles got %0d want 144", bn); end
        if (wn !== 64) begin bad++; $display("FAIL healthy_regwrite_cycles got %0d want 64", wn); end
        if (r5 !== 32'h5A5AA5A0) begin bad++; $display("FAIL healthy_reg5 got %h want 5a5aa5a0", r5); end
        if (b0.Done !== 1'b1 || b0.Pass !== 1'b1) begin bad++; $display("FAIL healthy_done_pass got %b%b want 11", b0.Done, b0.Pass); end
        if (b0.FailCount !== 6'd0) begin bad++; $display("FAIL healthy_failcount got %0d want 0", b0.FailCount); end
        if (b0.RegWrite !== 1'b0) begin bad++; $display("FAIL healthy_regwrite_done got %b want 0", b0.RegWrite); end
    endtask

    task automatic test_reg0_writable();
        int bn, wn;
        logic [31:0] r5;
        logic d0;
        fault = 1;
        run(1'b0, 1'b0, bn, wn, r5, d0);
        total += 4;
        if (d0 !== 1'b0) begin bad++; $display("FAIL reg0_done_cleared got %b want 0", d0); end
        if (bn !== 144) begin bad++; $display("FAIL reg0_busy_cycles got %0d want 144", bn); end
        if (b0.FailCount !== 6'd3 || b0.Pass !== 1'b0) begin bad++; $display("FAIL reg0_count_pass got %0d/%b want 3/0", b0.FailCount, b0.Pass); end
        if (b0.FailAddr !== 5'd0 || b0.FailPhase !== 2'd0) begin bad++; $display("FAIL reg0_first got %0d/%0d want 0/0", b0.FailAddr, b0.FailPhase); end
    endtask

    task automatic test_regwrite_ignored();
        int bn, wn;
        logic [31:0] r5;
        logic d0;
        fault = 2;
        run(1'b0, 1'b0, bn, wn, r5, d0);
        total += 3;
        if (d0 !== 1'b0) begin bad++; $display("FAIL rwign_done_cleared got %b want 0", d0); end
        if (b0.FailCount !== 6'd31 || b0.Pass !== 1'b0) begin bad++; $display("FAIL rwign_count_pass got %0d/%b want 31/0", b0.FailCount, b0.Pass); end
        if (b0.FailAddr !== 5'd1 || b0.FailPhase !== 2'd2) begin bad++; $display("FAIL rwign_first got %0d/%0d want 1/2", b0.FailAddr, b0.FailPhase); end
    endtask

    task automatic test_decoder();
        int bn, wn;
        logic [31:0] r5;
        logic d0;
        fault = 3; dec_src = 17; dec_dst = 16;
        run(1'b0, 1'b0, bn, wn, r5, d0);
        total += 2;
        if (b0.FailCount !== 6'd3 || b0.Pass !== 1'b0) begin bad++; $display("FAIL decoder_count_pass got %0d/%b want 3/0", b0.FailCount, b0.Pass); end
        if (b0.FailAddr !== 5'd16 || b0.FailPhase !== 2'd0) begin bad++; $display("FAIL decoder_first got %0d/%0d want 16/0", b0.FailAddr, b0.FailPhase); end
    endtask

    task automatic test_stop_on_fail();
        int bn, wn;
        logic [31:0] r5;
        logic d0;
        fault = 1;
        run(1'b1, 1'b1, bn, wn, r5, d0);
        total += 4;
        if (bn !== 33) begin bad++; $display("FAIL stop_busy_cycles got %0d want 33", bn); end
        if (b1.Done !== 1'b1) begin bad++; $display("FAIL stop_done got %b want 1", b1.Done); end
        if (b1.FailCount !== 6'd1 || b1.Pass !== 1'b0) begin bad++; $display("FAIL stop_count_pass got %0d/%b want 1/0", b1.FailCount, b1.Pass); end
        if (b1.FailAddr !== 5'd0 || b1.FailPhase !== 2'd0) begin bad++; $display("FAIL stop_first got %0d/%0d want 0/0", b1.FailAddr, b1.FailPhase); end
    endtask

    task automatic test_reset_midrun();
        int bn, wn;
        logic [31:0] r5;
        logic d0;
        fault = 0;
        @(negedge Clk); b0.Start = 1'b1;
        @(negedge Clk); b0.Start = 1'b0;
        bn = 1;
        while (bn < 50 && b0.Busy === 1'b1) begin @(negedge Clk); bn++; end
        total += 5;
        if (b0.RegWrite !== 1'b1 || bn !== 50) begin bad++; $display("FAIL midrun_pre got regwrite=%b cycle=%0d want 1/50", b0.RegWrite, bn); end
        Reset = 1'b1;
        #1;
        if (b0.RegWrite !== 1'b0) begin bad++; $display("FAIL midrun_regwrite got %b want 0", b0.RegWrite); end
        if (b0.Busy !== 1'b0 || b0.Done !== 1'b0) begin bad++; $display("FAIL midrun_busy_done got %b%b want 00", b0.Busy, b0.Done); end
        if (b0.WriteData !== 32'd0 || b0.WriteRegister !== 5'd0 || b0.FailCount !== 6'd0) begin
            bad++; $display("FAIL midrun_outputs got %h/%0d/%0d want 0/0/0", b0.WriteData, b0.WriteRegister, b0.FailCount);
        end
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;
        run(1'b0, 1'b0, bn, wn, r5, d0);
        if (bn !== 144 || b0.Pass !== 1'b1) begin bad++; $display("FAIL midrun_rerun got busy=%0d pass=%b want 144/1", bn, b0.Pass); end
    endtask

    task automatic test_random();
        int bn, wn, ec, ea, ep, eb;
        logic [31:0] r5;
        logic d0, s;
        for (int it = 0; it < 8; it++) begin
            fault = $urandom_range(0, 3);
            s = 1'($urandom_range(0, 1));
            dec_dst = $urandom_range(1, 31);
            dec_src = $urandom_range(1, 31);
            if (dec_src == dec_dst) dec_src = (dec_dst == 31) ? 1 : dec_dst + 1;
            model(fault, s, ec, ea, ep, eb);
            run(s, 1'b1, bn, wn, r5, d0);
            total += 3;
            if (bn !== eb) begin bad++; $display("FAIL rand_busy it=%0d fm=%0d s=%0d got %0d want %0d", it, fault, s, bn, eb); end
            if (int'(s ? b1.FailCount : b0.FailCount) !== ec || (s ? b1.Pass : b0.Pass) !== (ec == 0)) begin
                bad++; $display("FAIL rand_count it=%0d fm=%0d got %0d want %0d", it, fault, s ? b1.FailCount : b0.FailCount, ec);
            end
            if (int'(s ? b1.FailAddr : b0.FailAddr) !== ea || int'(s ? b1.FailPhase : b0.FailPhase) !== ep) begin
                bad++; $display("FAIL rand_first it=%0d fm=%0d got %0d/%0d want %0d/%0d", it, fault,
                                s ? b1.FailAddr : b0.FailAddr, s ? b1.FailPhase : b0.FailPhase, ea, ep);
            end
        end
    endtask

    initial begin
        b0.Start = 1'b0;
        b1.Start = 1'b0;
        test_reset();
        test_healthy();
        test_reg0_writable();
        test_healthy();
        test_regwrite_ignored();
        test_decoder();
        test_stop_on_fail();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
